benchmark1_stim_checker: RTL and testbench

//  Self-checking driver for the benchmark1 XOR/OR-reduction block.

---
 rtl/benchmark1_stim_checker.sv | 116 +++++++++++
 tb/tb_benchmark1_stim_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/benchmark1_stim_checker.sv
// LFSR stimulus driver and golden-model checker for benchmark1; start/done handshake to host.
// done rises NUM_VECTORS+1 edges after start; start is ignored while busy (no backpressure).
module benchmark1_stim_checker #(
  parameter int          NUM_VECTORS = 64,
  parameter logic [11:0] SEED        = 12'hACE,
  parameter int          CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             dut_out,
  output logic [5:0]       a_out,
  output logic [5:0]       b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count
);

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [11:0]      SEED_EFF = (SEED == 12'h000) ? 12'h001 : SEED;
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [11:0]      lfsr_q, lfsr_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             exp_q, exp_d;
  logic             cmp_v_q, cmp_v_d;
  logic             lfsr_fb;
  logic             exp_now;

  assign lfsr_fb = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];

  // a = lfsr[5:0], b = lfsr[11:6]
  assign exp_now = (lfsr_q[0] ^ lfsr_q[8]) ^ (lfsr_q[1] ^ lfsr_q[8])
                 ^ (lfsr_q[2] | (lfsr_q[7] & lfsr_q[6]))
                 ^ (~lfsr_q[3] | (lfsr_q[9] & lfsr_q[4]))
                 ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    vec_d   = vec_q;
    err_d   = err_q;
    exp_d   = exp_q;
    cmp_v_d = 1'b0;

    // exp_q lines up with the DUT's one-cycle register latency.
    if (cmp_v_q && (dut_out != exp_q) && (err_q != CNT_MAX)) begin
      err_d = err_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          lfsr_d  = SEED_EFF;
          vec_d   = '0;
          err_d   = '0;
        end
      end
      S_RUN: begin
        exp_d   = exp_now;
        cmp_v_d = 1'b1;
        lfsr_d  = {lfsr_q[10:0], lfsr_fb};
        vec_d   = vec_q + 1'b1;
        if (vec_q == LAST_VEC) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED_EFF;
      vec_q   <= '0;
      err_q   <= '0;
      exp_q   <= 1'b0;
      cmp_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
      cmp_v_q <= cmp_v_d;
    end
  end

  assign a_out     = lfsr_q[5:0];
  assign b_out     = lfsr_q[11:6];
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == '0);
  assign vec_count = vec_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_benchmark1_stim_checker.sv
// Directed bench for benchmark1_stim_checker: loopback, inverted loopback, reset, start
// handling, small-counter saturation, zero seed and golden spot checks.
module tb_benchmark1_stim_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic inv0 = 1'b0;
  logic spot_out = 1'b0;

  logic [5:0]  a0, b0, a1, b1, a2, b2, a3, b3;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic        busy2, done2, pass2, busy3, done3, pass3;
  logic [15:0] vec0, err0;
  logic [2:0]  vec1, err1;
  logic [3:0]  vec2, err2, vec3, err3;
  logic        m0_q, m1_q;
  logic        dut0_out, dut1_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Reference benchmark1: a0^a1 ^ (a2|(b1&b0)) ^ (~a3|(b3&a4)) ^ b4, registered.
  function automatic logic gold(input logic [4:0] a, input logic [4:0] b);
    return a[0] ^ a[1] ^ (a[2] | (b[1] & b[0])) ^ (~a[3] | (b[3] & a[4])) ^ b[4];
  endfunction

  function automatic logic [11:0] adv(input logic [11:0] l);
    return {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m0_q <= 1'b0;
      m1_q <= 1'b0;
    end else begin
      m0_q <= gold(a0[4:0], b0[4:0]);
      m1_q <= gold(a1[4:0], b1[4:0]);
    end
  end

  assign dut0_out = m0_q ^ inv0;
  assign dut1_out = ~m1_q;

  benchmark1_stim_checker u0 (
    .clock(clk), .reset(rst), .start(start0), .dut_out(dut0_out),
    .a_out(a0), .b_out(b0), .busy(busy0), .done(done0), .pass(pass0),
    .vec_count(vec0), .err_count(err0)
  );

  benchmark1_stim_checker #(.NUM_VECTORS(7), .SEED(12'h000), .CNT_W(3)) u1 (
    .clock(clk), .reset(rst), .start(start1), .dut_out(dut1_out),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_count(vec1), .err_count(err1)
  );

  benchmark1_stim_checker #(.NUM_VECTORS(1), .SEED(12'hFFF), .CNT_W(4)) u2 (
    .clock(clk), .reset(rst), .start(start2), .dut_out(spot_out),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec2), .err_count(err2)
  );

  benchmark1_stim_checker #(.NUM_VECTORS(1), .SEED(12'h000), .CNT_W(4)) u3 (
    .clock(clk), .reset(rst), .start(start2), .dut_out(spot_out),
    .a_out(a3), .b_out(b3), .busy(busy3), .done(done3), .pass(pass3),
    .vec_count(vec3), .err_count(err3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  initial begin
    int n;
    int seq_bad;
    int zero_seen;
    logic [11:0] mdl;

    // Reset state; ACE gives a=0x0E, b=0x2B
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pass", int'(pass0), 0);
    chk("rst_vec", int'(vec0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_a", int'(a0), 14);
    chk("rst_b", int'(b0), 43);

    // Run 1: true loopback, start pulsed again in RUN and DRAIN
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("r1_busy", int'(busy0), 1);
    n = 0;
    seq_bad = 0;
    mdl = 12'hACE;
    while (done0 !== 1'b1 && n < 200) begin
      if (n <= 64 && {b0, a0} !== mdl) seq_bad++;
      if (n < 64) mdl = adv(mdl);
      start0 = (n == 20) || (n == 64);
      step();
      n++;
    end
    start0 = 1'b0;
    chk("r1_edges", n, 65);
    chk("r1_lfsr_seq", seq_bad, 0);
    chk("r1_vec", int'(vec0), 64);
    chk("r1_err", int'(err0), 0);
    chk("r1_pass", int'(pass0), 1);
    step();
    step();
    chk("done_hold_ab", int'({b0, a0}), int'(mdl));
    chk("done_hold_done", int'(done0), 1);
    chk("done_hold_vec", int'(vec0), 64);

    // Run 2: restart from DONE with inverted loopback
    start0 = 1'b1;
    inv0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("r2_vec_clr", int'(vec0), 0);
    chk("r2_err_clr", int'(err0), 0);
    chk("r2_busy", int'(busy0), 1);
    chk("r2_first_a", int'(a0), 14);
    chk("r2_first_b", int'(b0), 43);
    n = 0;
    while (done0 !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("r2_edges", n, 65);
    chk("r2_err", int'(err0), 64);
    chk("r2_vec", int'(vec0), 64);
    chk("r2_pass", int'(pass0), 0);

    // Run 3: reset 10 cycles into RUN (compares land at edges E+2..E+10)
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (10) step();
    chk("r3_vec_mid", int'(vec0), 10);
    chk("r3_err_mid", int'(err0), 9);
    chk("r3_busy_mid", int'(busy0), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("r3_busy", int'(busy0), 0);
    chk("r3_done", int'(done0), 0);
    chk("r3_vec", int'(vec0), 0);
    chk("r3_err", int'(err0), 0);
    chk("r3_a", int'(a0), 14);
    chk("r3_b", int'(b0), 43);
    step();
    chk("r3_err_after", int'(err0), 0);
    chk("r3_a_idle", int'(a0), 14);
    inv0 = 1'b0;

    // Small counter, zero seed, inverted loopback
    chk("s0_a", int'(a1), 1);
    chk("s0_b", int'(b1), 0);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    zero_seen = 0;
    while (done1 !== 1'b1 && n < 100) begin
      if (a1 == 6'd0 && b1 == 6'd0) zero_seen = 1;
      step();
      n++;
    end
    chk("s0_edges", n, 8);
    chk("s0_err_sat", int'(err1), 7);
    chk("s0_vec", int'(vec1), 7);
    chk("s0_pass", int'(pass1), 0);
    chk("s0_nonzero", zero_seen, 0);

    // Golden spot checks: a=3F,b=3F -> 1 (u2); a=01,b=00 -> 0 (u3)
    chk("sp_a2", int'(a2), 63);
    chk("sp_b2", int'(b2), 63);
    chk("sp_a3", int'(a3), 1);
    chk("sp_b3", int'(b3), 0);
    spot_out = 1'b1;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    step();
    chk("sp1_done2", int'(done2), 1);
    chk("sp1_done3", int'(done3), 1);
    chk("sp1_err2", int'(err2), 0);
    chk("sp1_err3", int'(err3), 1);
    chk("sp1_pass2", int'(pass2), 1);
    chk("sp1_pass3", int'(pass3), 0);
    spot_out = 1'b0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    step();
    step();
    chk("sp2_err2", int'(err2), 1);
    chk("sp2_err3", int'(err3), 0);
    chk("sp2_pass3", int'(pass3), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
